// File: rtl/neuron_spike_rate_decoder.sv
// Spike-rate decoder: counts spikes over a fixed window and reports the count and
// first-spike latency through a valid/ready handshake, with a sticky overrun flag.
module neuron_spike_rate_decoder #(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             spike_in,
    output logic [CNT_W-1:0] rate,
    output logic [CNT_W-1:0] first_lat,
    output logic             rate_valid,
    input  logic             rate_ready,
    output logic             overrun,
    input  logic             clr_ovr
);

    typedef enum logic [0:0] {IDLE = 1'b0, COUNT = 1'b1} state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] ALL_ONES = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        if (inc && (v != ALL_ONES)) begin
            return v + ONE;
        end else begin
            return v;
        end
    endfunction

    state_t           state_r;
    logic [CNT_W-1:0] win_cnt_r;
    logic [CNT_W-1:0] spike_cnt_r;
    logic [CNT_W-1:0] lat_reg_r;
    logic             seen_spike_r;
    logic [CNT_W-1:0] rate_r;
    logic [CNT_W-1:0] first_lat_r;
    logic             rate_valid_r;
    logic             overrun_r;

    logic [CNT_W-1:0] idx_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic [CNT_W-1:0] lat_next_s;
    logic [CNT_W-1:0] result_lat_s;
    logic             win_end_s;
    logic             accept_s;
    logic             ovr_set_s;

    // Next-sample arithmetic: index, saturated count, latency capture and window end.
    always_comb begin
        idx_s = ZERO;
        case (state_r)
            IDLE:    idx_s = ZERO;
            COUNT:   idx_s = win_cnt_r;
            default: idx_s = ZERO;
        endcase
        cnt_next_s = sat_inc(spike_cnt_r, spike_in);
        if (spike_in && !seen_spike_r) begin
            lat_next_s = idx_s;
        end else begin
            lat_next_s = lat_reg_r;
        end
        // A spike on the final sample must still count as the first spike.
        if (seen_spike_r || spike_in) begin
            result_lat_s = lat_next_s;
        end else begin
            result_lat_s = ALL_ONES;
        end
        win_end_s = ena && (idx_s == LAST_IDX);
        accept_s  = rate_valid_r && rate_ready;
        ovr_set_s = win_end_s && rate_valid_r && !rate_ready;
    end

    // Window state machine, result registers, handshake and overrun flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            win_cnt_r    <= ZERO;
            spike_cnt_r  <= ZERO;
            lat_reg_r    <= ZERO;
            seen_spike_r <= 1'b0;
            rate_r       <= ZERO;
            first_lat_r  <= ZERO;
            rate_valid_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            if (ena) begin
                state_r   <= COUNT;
                lat_reg_r <= lat_next_s;
                if (win_end_s) begin
                    win_cnt_r    <= ZERO;
                    spike_cnt_r  <= ZERO;
                    seen_spike_r <= 1'b0;
                    rate_r       <= cnt_next_s;
                    first_lat_r  <= result_lat_s;
                    rate_valid_r <= 1'b1;
                end else begin
                    win_cnt_r    <= idx_s + ONE;
                    spike_cnt_r  <= cnt_next_s;
                    seen_spike_r <= seen_spike_r | spike_in;
                    if (accept_s) begin
                        rate_valid_r <= 1'b0;
                    end else begin
                        rate_valid_r <= rate_valid_r;
                    end
                end
            end else begin
                state_r      <= IDLE;
                win_cnt_r    <= ZERO;
                spike_cnt_r  <= ZERO;
                seen_spike_r <= 1'b0;
                if (accept_s) begin
                    rate_valid_r <= 1'b0;
                end else begin
                    rate_valid_r <= rate_valid_r;
                end
            end
            if (ovr_set_s) begin
                overrun_r <= 1'b1;
            end else if (clr_ovr) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    assign rate       = rate_r;
    assign first_lat  = first_lat_r;
    assign rate_valid = rate_valid_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_neuron_spike_rate_decoder.sv
// Bench for neuron_spike_rate_decoder: vector table, directed corner sequences and
// a randomized run against a window-list reference model.
module tb_neuron_spike_rate_decoder;

    localparam int WINDOW = 16;
    localparam int CNT_W  = 8;
    localparam int NONE   = 255;

    logic             clk;
    logic             rst_n;
    logic             ena;
    logic             spike_in;
    logic [CNT_W-1:0] rate;
    logic [CNT_W-1:0] first_lat;
    logic             rate_valid;
    logic             rate_ready;
    logic             overrun;
    logic             clr_ovr;

    int total;
    int bad;

    // reference model state
    bit win_q[$];
    int m_rate;
    int m_lat;
    int m_valid;
    int m_ovr;

    typedef struct {
        bit r, e, s, rdy, c;
        int x_rate, x_lat, x_valid, x_ovr;
    } vec_t;

    vec_t vecs[$];

    neuron_spike_rate_decoder #(.WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .spike_in(spike_in),
        .rate(rate), .first_lat(first_lat), .rate_valid(rate_valid),
        .rate_ready(rate_ready), .overrun(overrun), .clr_ovr(clr_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behaviour at one clock edge, derived from the window rules directly.
    task automatic model_edge();
        int sum;
        int first;
        bit loaded;
        bit ovr_set;
        loaded  = 1'b0;
        ovr_set = 1'b0;
        if (!rst_n) begin
            win_q.delete();
            m_rate = 0; m_lat = 0; m_valid = 0; m_ovr = 0;
            return;
        end
        if (ena) begin
            win_q.push_back(spike_in);
            if (win_q.size() == WINDOW) begin
                sum = 0;
                first = NONE;
                for (int i = 0; i < WINDOW; i++) begin
                    if (win_q[i]) begin
                        sum++;
                        if (first == NONE) first = i;
                    end
                end
                if (sum > 255) sum = 255;
                loaded = 1'b1;
                win_q.delete();
            end
        end else begin
            win_q.delete();
        end
        if (loaded) begin
            ovr_set = (m_valid == 1) && !rate_ready;
            m_valid = 1; m_rate = sum; m_lat = first;
        end else if (m_valid == 1 && rate_ready) begin
            m_valid = 0;
        end
        if (ovr_set) m_ovr = 1;
        else if (clr_ovr) m_ovr = 0;
    endtask

    task automatic cyc(input bit r, input bit e, input bit s, input bit rdy, input bit c);
        rst_n = r; ena = e; spike_in = s; rate_ready = rdy; clr_ovr = c;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".rate"}, int'(rate), m_rate);
        check({tag, ".first_lat"}, int'(first_lat), m_lat);
        check({tag, ".rate_valid"}, int'(rate_valid), m_valid);
        check({tag, ".overrun"}, int'(overrun), m_ovr);
    endtask

    task automatic add_vec(input bit r, e, s, rdy, c, input int xr, xl, xv, xo);
        vec_t v;
        v.r = r; v.e = e; v.s = s; v.rdy = rdy; v.c = c;
        v.x_rate = xr; v.x_lat = xl; v.x_valid = xv; v.x_ovr = xo;
        vecs.push_back(v);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0; ena = 1'b1; spike_in = 1'b1; rate_ready = 1'b0; clr_ovr = 1'b0;

        // Table: reset with active inputs, spikes at 5 and 9, then an empty window.
        for (int i = 0; i < 3; i++) add_vec(0, 1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < WINDOW; i++)
            add_vec(1, 1, (i == 5 || i == 9), 1, 0,
                    (i == WINDOW-1) ? 2 : 0, (i == WINDOW-1) ? 5 : 0, (i == WINDOW-1) ? 1 : 0, 0);
        for (int i = 0; i < WINDOW; i++)
            add_vec(1, 1, 0, 1, 0,
                    (i == WINDOW-1) ? 0 : 2, (i == WINDOW-1) ? NONE : 5, (i == WINDOW-1) ? 1 : 0, 0);
        add_vec(1, 0, 1, 1, 0, 0, NONE, 0, 0);

        foreach (vecs[k]) begin
            cyc(vecs[k].r, vecs[k].e, vecs[k].s, vecs[k].rdy, vecs[k].c);
            check($sformatf("vec%0d.rate", k), int'(rate), vecs[k].x_rate);
            check($sformatf("vec%0d.first_lat", k), int'(first_lat), vecs[k].x_lat);
            check($sformatf("vec%0d.rate_valid", k), int'(rate_valid), vecs[k].x_valid);
            check($sformatf("vec%0d.overrun", k), int'(overrun), vecs[k].x_ovr);
        end

        // Constant spiking: one-cycle valid pulse every WINDOW cycles.
        for (int k = 1; k <= 3 * WINDOW; k++) begin
            cyc(1, 1, 1, 1, 0);
            check("const.rate_valid", int'(rate_valid), (k % WINDOW == 0) ? 1 : 0);
            if (k % WINDOW == 0) begin
                check("const.rate", int'(rate), WINDOW);
                check("const.first_lat", int'(first_lat), 0);
            end
        end
        cyc(1, 0, 0, 1, 0);
        check_model("const_end");

        // Two unconsumed windows (3 then 7 spikes) -> overrun; clear; consume.
        for (int i = 0; i < WINDOW; i++) cyc(1, 1, (i < 3), 0, 0);
        check("ovr1.rate", int'(rate), 3);
        check("ovr1.overrun", int'(overrun), 0);
        for (int i = 0; i < WINDOW; i++) cyc(1, 1, (i >= 4 && i < 11), 0, 0);
        check("ovr2.rate", int'(rate), 7);
        check("ovr2.first_lat", int'(first_lat), 4);
        check("ovr2.rate_valid", int'(rate_valid), 1);
        check("ovr2.overrun", int'(overrun), 1);
        cyc(1, 0, 0, 0, 1);
        check("clr.overrun", int'(overrun), 0);
        check("clr.rate_valid", int'(rate_valid), 1);
        cyc(1, 0, 0, 1, 0);
        check("drain.rate_valid", int'(rate_valid), 0);

        // Pause at index 7 after 5 spikes; partial window discarded.
        for (int i = 0; i < 7; i++) cyc(1, 1, (i < 5), 1, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 1, 1, 0);
            check("pause.rate_valid", int'(rate_valid), 0);
        end
        for (int i = 0; i < WINDOW; i++) begin
            cyc(1, 1, (i == 3 || i == 10), 1, 0);
            check("resume.rate_valid", int'(rate_valid), (i == WINDOW-1) ? 1 : 0);
        end
        check("resume.rate", int'(rate), 2);
        check("resume.first_lat", int'(first_lat), 3);

        // Spike on the last sample only -> latency WINDOW-1.
        for (int i = 0; i < WINDOW; i++) cyc(1, 1, (i == WINDOW-1), 1, 0);
        check("last.rate", int'(rate), 1);
        check("last.first_lat", int'(first_lat), WINDOW-1);

        // Reset mid-window while a result is pending.
        for (int i = 0; i < 5; i++) cyc(1, 1, 1, 0, 0);
        check("prerst.rate_valid", int'(rate_valid), 1);
        cyc(0, 1, 1, 0, 0);
        check("rst.rate", int'(rate), 0);
        check("rst.first_lat", int'(first_lat), 0);
        check("rst.rate_valid", int'(rate_valid), 0);
        check("rst.overrun", int'(overrun), 0);
        for (int i = 0; i < WINDOW; i++) begin
            cyc(1, 1, (i == 8), 1, 0);
            check("postrst.rate_valid", int'(rate_valid), (i == WINDOW-1) ? 1 : 0);
        end
        check("postrst.first_lat", int'(first_lat), 8);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 19) != 0),
                $urandom_range(0, 1), ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
            check_model("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
